doubleinteg1: RTL

- Gated double integrator over an N-sample lag; the exact inverse of the gated double-difference filter (1 - z^-N)^2.
- Computes y = x / (1 - z^-N)^2 in modular arithmetic, one gated sample at a time.
- Sits on the reconstruction side of a compressed or differenced data path, e.g. after a decimated link or a waveform-buffer readout.
- Feeding it the double-difference of a stream reproduces that stream exactly, wrap-arounds included.

---
 rtl/doubleinteg1_gated_recirc.sv | 52 +++++
 rtl/doubleinteg1.sv | 81 ++++++++
 2 files changed

// File: rtl/doubleinteg1_gated_recirc.sv
// One gated N-deep recirculating accumulator: out[k] = in[k] + out[k-N], wrapping modulo 2^dw.
// Entry 0 of the lag line is the stage output; ovf_pulse flags a signed overflow on an accepted add.
module gated_recirc #(
   parameter int dw  = 28,
   parameter int len = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          gate,
   input  logic [dw-1:0] din,
   output logic [dw-1:0] dout,
   output logic          ovf_pulse
);

   logic [len-1:0][dw-1:0] hist_q;
   logic [len-1:0][dw-1:0] hist_d;
   logic [dw-1:0]          sum_s;
   logic                   sum_ovf_s;

   always_comb begin
      sum_s     = din + hist_q[len-1];
      sum_ovf_s = (din[dw-1] == hist_q[len-1][dw-1]) && (sum_s[dw-1] != din[dw-1]);
   end

   always_comb begin
      hist_d    = hist_q;
      ovf_pulse = 1'b0;
      if (clear) begin
         hist_d = {(len*dw){1'b0}};
      end else if (gate) begin
         for (int k = len - 1; k > 0; k--) begin
            hist_d[k] = hist_q[k-1];
         end
         hist_d[0] = sum_s;
         ovf_pulse = sum_ovf_s;
      end else begin
         hist_d = hist_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hist_q <= {(len*dw){1'b0}};
      end else begin
         hist_q <= hist_d;
      end
   end

   assign dout = hist_q[0];

endmodule

// File: rtl/doubleinteg1.sv
// Gated double integrator over an N-sample lag: y = x / (1 - z^-N)^2, wrapping modulo 2^dw.
// Two gated_recirc stages, a two-deep gate pipeline, a clear-suppress flag and a sticky overflow flag.
module doubleinteg1 #(
   parameter int dw      = 28,
   parameter int gw      = 1,
   parameter int dsr_len = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic [dw-1:0] d_in,
   input  logic [gw-1:0] g_in,
   output logic [dw-1:0] d_out,
   output logic [gw-1:0] g_out,
   output logic          ovf
);

   logic [dw-1:0] y1_s;
   logic          ovf1_s;
   logic          ovf2_s;
   logic          gate2_s;
   logic [gw-1:0] valid1_q;
   logic [gw-1:0] valid1_d;
   logic [gw-1:0] g_out_q;
   logic [gw-1:0] g_out_d;
   logic          supp_q;
   logic          supp_d;
   logic          ovf_q;
   logic          ovf_d;

   gated_recirc #(.dw(dw), .len(dsr_len)) u_stage1 (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .gate      (g_in[0]),
      .din       (d_in),
      .dout      (y1_s),
      .ovf_pulse (ovf1_s)
   );

   gated_recirc #(.dw(dw), .len(dsr_len)) u_stage2 (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .gate      (gate2_s),
      .din       (y1_s),
      .dout      (d_out),
      .ovf_pulse (ovf2_s)
   );

   // A sample discarded by clear must not reach stage 2 on the following cycle either.
   always_comb begin
      valid1_d = g_in;
      g_out_d  = valid1_q;
      supp_d   = clear & g_in[0];
      gate2_s  = valid1_q[0] & ~supp_q;
      if (clear) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q | ovf1_s | ovf2_s;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid1_q <= {gw{1'b0}};
         g_out_q  <= {gw{1'b0}};
         supp_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         valid1_q <= valid1_d;
         g_out_q  <= g_out_d;
         supp_q   <= supp_d;
         ovf_q    <= ovf_d;
      end
   end

   assign g_out = g_out_q;
   assign ovf   = ovf_q;

endmodule
